// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM.
// Moore outputs per state; IF fetch enables are qualified by mem_ready and
// every write enable / strobe is forced low while reset is high.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic       IorD,
  output logic       IRWr,
  output logic       MemRead,
  output logic       MemWr,
  output logic       RegWr,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUop,
  output logic       Extop,
  output logic [3:0] dbg_state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BEQ  = 4'd8,
    S_JMP  = 4'd9,
    S_IEX  = 4'd10,
    S_IWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state, next;
  logic [5:0] ir_op;  // opcode captured in ID, so later op wiggles are ignored

  // state register, synchronous reset to IF
  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= next;
  end

  // hold the opcode seen in ID for the MADR/IEX decode
  always_ff @(posedge clk) begin
    if (reset)            ir_op <= '0;
    else if (state == S_ID) ir_op <= op;
  end

  // next-state and per-state outputs; strobes killed while reset is high
  always_comb begin
    next       = state;
    PCWr       = 1'b0;
    PCWrCond   = 1'b0;
    IorD       = 1'b0;
    IRWr       = 1'b0;
    MemRead    = 1'b0;
    MemWr      = 1'b0;
    RegWr      = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUop      = 3'b000;
    Extop      = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWr    = mem_ready;
        PCWr    = mem_ready;
        if (mem_ready) next = S_ID;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        Extop   = 1'b1;
        case (op)
          OP_LW, OP_SW:     next = S_MADR;
          OP_R:             next = S_REX;
          OP_BEQ:           next = S_BEQ;
          OP_J:             next = S_JMP;
          OP_ORI, OP_ADDIU: next = S_IEX;
          default: begin
            next       = S_IF;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Extop   = 1'b1;
        next    = (ir_op == OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) next = S_MWB;
      end
      S_MWB: begin
        RegWr    = 1'b1;
        MemtoReg = 1'b1;
        next     = S_IF;
      end
      S_MWR: begin
        MemWr = 1'b1;
        IorD  = 1'b1;
        if (mem_ready) next = S_IF;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        ALUop   = 3'b001;
        next    = S_RWB;
      end
      S_RWB: begin
        RegWr  = 1'b1;
        RegDst = 1'b1;
        next   = S_IF;
      end
      S_BEQ: begin
        ALUSrcA  = 1'b1;
        ALUop    = 3'b100;
        PCWrCond = 1'b1;
        PCSrc    = 2'b01;
        next     = S_IF;
      end
      S_JMP: begin
        PCWr  = 1'b1;
        PCSrc = 2'b10;
        next  = S_IF;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = (ir_op == OP_ORI) ? 3'b010 : 3'b000;
        Extop   = (ir_op != OP_ORI);
        next    = S_IWB;
      end
      S_IWB: begin
        RegWr = 1'b1;
        next  = S_IF;
      end
      default: next = S_IF;
    endcase
    if (reset) begin
      PCWr       = 1'b0;
      PCWrCond   = 1'b0;
      IRWr       = 1'b0;
      MemRead    = 1'b0;
      MemWr      = 1'b0;
      RegWr      = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle stimulus tables, expected output
// vectors from a spec-level model pushed to a scoreboard queue and popped
// when the DUT outputs are sampled mid-cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWr, PCWrCond, IorD, IRWr, MemRead, MemWr, RegWr, RegDst, MemtoReg;
  logic       ALUSrcA, Extop, illegal_op;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUop;
  logic [3:0] dbg_state;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BQ = 6'b000100, ORI = 6'b001101, ADI = 6'b001001,
                         J = 6'b000010, BAD = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic pcwr, pcwrc, iord, irwr, mrd, mwr, regwr, regdst, m2r, srca;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluop;
    logic ext, ill;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rs;
    logic       mr;
    logic [5:0] op;
  } cyc_t;

  outs_t      sb[$];
  outs_t      got, exp_v;
  logic [5:0] ir_q = '0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .IRWr(IRWr),
    .MemRead(MemRead), .MemWr(MemWr), .RegWr(RegWr), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUop(ALUop), .Extop(Extop), .dbg_state(dbg_state), .illegal_op(illegal_op)
  );

  assign got = '{st: dbg_state, pcwr: PCWr, pcwrc: PCWrCond, iord: IorD,
                 irwr: IRWr, mrd: MemRead, mwr: MemWr, regwr: RegWr,
                 regdst: RegDst, m2r: MemtoReg, srca: ALUSrcA, srcb: ALUSrcB,
                 pcsrc: PCSrc, aluop: ALUop, ext: Extop, ill: illegal_op};

  function automatic cyc_t c(input int st, input bit rs, input bit mr, input logic [5:0] o);
    c = '{st: 4'(st), rs: rs, mr: mr, op: o};
  endfunction

  function automatic bit legal(input logic [5:0] o);
    legal = (o == R) || (o == LW) || (o == SW) || (o == BQ) ||
            (o == ORI) || (o == ADI) || (o == J);
  endfunction

  // expected outputs for one cycle, written from the state table
  function automatic outs_t model(input cyc_t t, input logic [5:0] irop);
    outs_t o;
    bit    en;
    o    = '0;
    o.st = t.st;
    en   = !t.rs;
    case (t.st)
      4'd0:  begin o.mrd = en; o.srcb = 2'b01; o.irwr = t.mr & en; o.pcwr = t.mr & en; end
      4'd1:  begin o.srcb = 2'b11; o.ext = 1'b1; o.ill = !legal(t.op) & en; end
      4'd2:  begin o.srca = 1'b1; o.srcb = 2'b10; o.ext = 1'b1; end
      4'd3:  begin o.mrd = en; o.iord = 1'b1; end
      4'd4:  begin o.regwr = en; o.m2r = 1'b1; end
      4'd5:  begin o.mwr = en; o.iord = 1'b1; end
      4'd6:  begin o.srca = 1'b1; o.aluop = 3'b001; end
      4'd7:  begin o.regwr = en; o.regdst = 1'b1; end
      4'd8:  begin o.srca = 1'b1; o.aluop = 3'b100; o.pcwrc = en; o.pcsrc = 2'b01; end
      4'd9:  begin o.pcwr = en; o.pcsrc = 2'b10; end
      4'd10: begin
        o.srca = 1'b1; o.srcb = 2'b10;
        o.aluop = (irop == ORI) ? 3'b010 : 3'b000;
        o.ext   = (irop == ORI) ? 1'b0 : 1'b1;
      end
      4'd11: o.regwr = en;
      default: ;
    endcase
    return o;
  endfunction

  task automatic test_reset();
    cyc_t t[$];
    t = '{c(0,1,1,LW), c(0,1,1,LW), c(0,0,0,LW), c(0,0,0,R)};
    foreach (t[i]) begin
      @(negedge clk);
      reset = t[i].rs; mem_ready = t[i].mr; op = t[i].op;
      sb.push_back(model(t[i], ir_q));
      if (t[i].st == 4'd1 && !t[i].rs) ir_q = t[i].op;
      #1 exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset cyc%0d got %h required %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_lw();
    cyc_t t[$];
    t = '{c(0,0,1,LW), c(1,0,1,LW), c(2,0,1,LW), c(3,0,1,LW), c(4,0,1,LW), c(0,0,0,LW)};
    foreach (t[i]) begin
      @(negedge clk);
      reset = t[i].rs; mem_ready = t[i].mr; op = t[i].op;
      sb.push_back(model(t[i], ir_q));
      if (t[i].st == 4'd1 && !t[i].rs) ir_q = t[i].op;
      #1 exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL lw cyc%0d got %h required %h", i, got, exp_v);
      end
    end
  endtask

  // IF wait, mem_ready ignored in MADR, three wait cycles in MWR
  task automatic test_sw();
    cyc_t t[$];
    t = '{c(0,0,0,SW), c(0,0,1,SW), c(1,0,0,SW), c(2,0,1,SW), c(5,0,0,LW),
          c(5,0,0,R), c(5,0,0,BAD), c(5,0,1,SW), c(0,0,0,SW)};
    foreach (t[i]) begin
      @(negedge clk);
      reset = t[i].rs; mem_ready = t[i].mr; op = t[i].op;
      sb.push_back(model(t[i], ir_q));
      if (t[i].st == 4'd1 && !t[i].rs) ir_q = t[i].op;
      #1 exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL sw cyc%0d got %h required %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_beq();
    cyc_t t[$];
    t = '{c(0,0,1,BQ), c(1,0,1,BQ), c(8,0,1,BQ), c(0,0,0,BQ)};
    foreach (t[i]) begin
      @(negedge clk);
      reset = t[i].rs; mem_ready = t[i].mr; op = t[i].op;
      sb.push_back(model(t[i], ir_q));
      if (t[i].st == 4'd1 && !t[i].rs) ir_q = t[i].op;
      #1 exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL beq cyc%0d got %h required %h", i, got, exp_v);
      end
    end
  endtask

  // ori then addiu; op is scrambled after ID to show the held opcode is used
  task automatic test_imm();
    cyc_t t[$];
    t = '{c(0,0,1,ORI), c(1,0,0,ORI), c(10,0,1,BAD), c(11,0,0,ADI), c(0,0,1,ADI),
          c(1,0,0,ADI), c(10,0,0,ORI), c(11,0,1,BAD), c(0,0,0,R)};
    foreach (t[i]) begin
      @(negedge clk);
      reset = t[i].rs; mem_ready = t[i].mr; op = t[i].op;
      sb.push_back(model(t[i], ir_q));
      if (t[i].st == 4'd1 && !t[i].rs) ir_q = t[i].op;
      #1 exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL imm cyc%0d got %h required %h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_illegal();
    cyc_t t[$];
    t = '{c(0,0,1,BAD), c(1,0,1,BAD), c(0,0,0,BAD), c(0,0,1,6'b000001),
          c(1,0,0,6'b000001), c(0,0,0,R)};
    foreach (t[i]) begin
      @(negedge clk);
      reset = t[i].rs; mem_ready = t[i].mr; op = t[i].op;
      sb.push_back(model(t[i], ir_q));
      if (t[i].st == 4'd1 && !t[i].rs) ir_q = t[i].op;
      #1 exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL illegal cyc%0d got %h required %h", i, got, exp_v);
      end
    end
  endtask

  // R-type, j and lw issued without idle cycles between them
  task automatic test_back_to_back();
    cyc_t t[$];
    t = '{c(0,0,1,R), c(1,0,0,R), c(6,0,1,J), c(7,0,0,J), c(0,0,1,J), c(1,0,0,J),
          c(9,0,1,LW), c(0,0,1,LW), c(1,0,0,LW), c(2,0,0,SW), c(3,0,1,SW),
          c(4,0,0,SW), c(0,0,0,R)};
    foreach (t[i]) begin
      @(negedge clk);
      reset = t[i].rs; mem_ready = t[i].mr; op = t[i].op;
      sb.push_back(model(t[i], ir_q));
      if (t[i].st == 4'd1 && !t[i].rs) ir_q = t[i].op;
      #1 exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL b2b cyc%0d got %h required %h", i, got, exp_v);
      end
    end
  endtask

  // reset landing in an MRD wait and in an MWR wait, then a clean fetch
  task automatic test_reset_mid();
    cyc_t t[$];
    t = '{c(0,0,1,LW), c(1,0,0,LW), c(2,0,0,LW), c(3,0,0,LW), c(3,1,0,LW),
          c(0,1,1,LW), c(0,0,1,LW), c(1,0,0,SW), c(2,0,0,SW), c(5,0,0,SW),
          c(5,1,1,SW), c(0,0,1,BQ), c(1,0,0,BQ), c(8,0,0,BQ), c(0,0,0,R)};
    foreach (t[i]) begin
      @(negedge clk);
      reset = t[i].rs; mem_ready = t[i].mr; op = t[i].op;
      sb.push_back(model(t[i], ir_q));
      if (t[i].st == 4'd1 && !t[i].rs) ir_q = t[i].op;
      #1 exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL rst_mid cyc%0d got %h required %h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    op = '0;
    @(posedge clk);
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_imm();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; state encoding is internal but SHALL be exposed on dbg_state as listed in REQ-012.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  opcode field of the instruction register (IR[31:26]), valid from ID onward.
REQ-005 mem_ready  input  1  memory handshake; high in the cycle an access completes.
REQ-006 PCWr, PCWrCond  output  1 each  unconditional / branch-conditional PC write enables.
REQ-007 IorD, IRWr  output  1 each  memory address select (0=PC, 1=ALUOut) / IR load enable.
REQ-008 MemRead, MemWr  output  1 each  memory read / write strobes.
REQ-009 RegWr, RegDst, MemtoReg  output  1 each  register write enable, dest select (1=rd, 0=rt), write-data select (1=MDR).
REQ-010 ALUSrcA  output  1 (0=PC, 1=A); ALUSrcB  output  2 (00=B, 01=const 4, 10=ext imm, 11=ext imm<<2).
REQ-011 PCSrc  output  2 (00=ALU result, 01=ALUOut, 10=jump target); ALUop  output  3; Extop  output  1 (1=sign, 0=zero extend).
REQ-012 dbg_state  output  4  current state code; illegal_op  output  1  one-cycle pulse on unknown opcode.

Function
REQ-013 Opcodes decoded: R-type 000000, lw 100011, sw 101011, beq 000100, ori 001101, addiu 001001, j 000010; all others illegal.
REQ-014 States and codes: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, REX=6, RWB=7, BEQ=8, JMP=9, IEX=10, IWB=11.
REQ-015 All outputs SHALL be Moore (functions of state only), except MemRead/MemWr/IRWr/PCWr, which are qualified by mem_ready where stated.
REQ-016 IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=000, PCSrc=00; IRWr=PCWr=mem_ready; stay in IF until mem_ready, then go to ID.
REQ-017 ID: ALUSrcA=0, ALUSrcB=11, ALUop=000, Extop=1 (branch target precompute); next state by op: lw/sw->MADR, R->REX, beq->BEQ, j->JMP, ori/addiu->IEX, illegal->IF with illegal_op=1.
REQ-018 MADR: ALUSrcA=1, ALUSrcB=10, Extop=1, ALUop=000; lw->MRD, sw->MWR.
REQ-019 MRD: MemRead=1, IorD=1; hold until mem_ready, then MWB. MWB: RegWr=1, RegDst=0, MemtoReg=1; then IF.
REQ-020 MWR: MemWr=1, IorD=1; hold until mem_ready, then IF.
REQ-021 REX: ALUSrcA=1, ALUSrcB=00, ALUop=001; then RWB. RWB: RegWr=1, RegDst=1, MemtoReg=0; then IF.
REQ-022 BEQ: ALUSrcA=1, ALUSrcB=00, ALUop=100, PCWrCond=1, PCSrc=01; then IF.
REQ-023 JMP: PCWr=1, PCSrc=10; then IF.
REQ-024 IEX: ALUSrcA=1, ALUSrcB=10, ALUop=010 for ori / 000 for addiu, Extop=0 for ori / 1 for addiu; then IWB. IWB: RegWr=1, RegDst=0, MemtoReg=0; then IF.
REQ-025 Latency excluding memory wait: lw 5, sw 4, R/ori/addiu 4, beq 3, j 3 cycles; each cycle mem_ready is low adds exactly one cycle in IF/MRD/MWR.
REQ-026 Outputs not listed for a state SHALL be 0; RegWr, MemWr, PCWr, PCWrCond, IRWr SHALL never be 1 outside the states named above.
REQ-027 op SHALL be sampled only in ID and, for MADR/IEX ALUop/Extop decode, from the held IR; op changes in other states SHALL have no effect.
REQ-028 mem_ready asserted outside IF/MRD/MWR SHALL be ignored.

Reset
REQ-029 reset high at a rising edge SHALL force state IF in the next cycle, regardless of current state, including during memory waits.
REQ-030 While reset is high all write enables and strobes (PCWr, PCWrCond, IRWr, MemRead, MemWr, RegWr) and illegal_op SHALL be 0; dbg_state=0 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-MWR SHALL drop MemWr in the same cycle reset is seen high; no partial write enable may persist.

Verification
REQ-032 lw (op=100011), mem_ready=1 always -> dbg_state 0,1,2,3,4,0; RegWr=1 and MemtoReg=1 only in state 4.
REQ-033 sw with mem_ready low for 3 cycles in MWR -> MemWr=1 for 4 cycles, then IF; RegWr never 1.
REQ-034 beq -> states 0,1,8,0; PCWrCond=1, ALUop=100, PCSrc=01 in state 8 only.
REQ-035 ori then addiu -> in IEX ALUop=010/Extop=0 then ALUop=000/Extop=1; RegDst=0 in IWB.
REQ-036 op=111111 in ID -> illegal_op pulses 1 cycle, next state IF, no write enables asserted.
REQ-037 reset asserted during MRD wait -> next cycle dbg_state=0, MemRead=0 while reset high; normal fetch resumes after release.
